// File: rtl/dsm_seq_ctrl_pkg.sv
// Shared constants for the delta-sigma sequencer: widths, timing,
// LFSR polynomial and FSM state encodings.
package dsm_seq_ctrl_pkg;

   localparam int DSM_T_BITS    = 15;
   localparam int DSM_FLUSH_CYC = 4;

   localparam logic [15:0] DSM_LFSR_SEED = 16'hACE1;
   // Fibonacci taps x^16+x^14+x^13+x^11 on a right-shifting register
   localparam logic [15:0] DSM_LFSR_TAPS = 16'h002D;

   typedef logic [1:0] dsm_state_t;

   localparam dsm_state_t ST_IDLE    = 2'd0;
   localparam dsm_state_t ST_FLUSH   = 2'd1;
   localparam dsm_state_t ST_RUN     = 2'd2;
   localparam dsm_state_t ST_RECOVER = 2'd3;

endpackage

// File: rtl/dsm_seq_ctrl_fifo.sv
// Synchronous sample buffer with full/empty flags and a flush that
// empties it in one clock.
module sample_fifo #(
   parameter int W     = 15,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/dsm_seq_ctrl.sv
// Sequencer feeding a delta-sigma modulator: buffered samples paced by
// the oversampling ratio, dither generation and overload recovery.
module dsm_seq_ctrl
   import dsm_seq_ctrl_pkg::*;
#(
   parameter int T_BITS     = DSM_T_BITS,
   parameter int FIFO_DEPTH = 4,
   parameter int FLUSH_CYC  = DSM_FLUSH_CYC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [7:0]        osr,
   input  logic              dith_en,
   input  logic [7:0]        ovl_limit,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [T_BITS-1:0] s_data,
   input  logic [1:0]        pwm,
   output logic              dsm_reset,
   output logic [T_BITS-1:0] dsm_vin,
   output logic [T_BITS-6:0] dsm_dith,
   output logic              underrun,
   output logic [7:0]        overload_cnt,
   output logic [1:0]        state
);

   localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

   dsm_state_t        state_nxt;
   logic [7:0]        osr_eff;
   logic [7:0]        tick_cnt;
   logic [7:0]        flush_cnt;
   logic [7:0]        run_cnt;
   logic [7:0]        run_nxt;
   logic [1:0]        pwm_prev;
   logic [15:0]       lfsr;
   logic              flush_done;
   logic              tick;
   logic              ovl_hit;
   logic              tick_ev;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [T_BITS-1:0] fifo_head;

   assign osr_eff    = (osr == 8'd0) ? 8'd1 : osr;
   assign flush_done = (flush_cnt == FLUSH_LAST);
   assign tick       = (state == ST_RUN) && (tick_cnt >= osr_eff - 8'd1);
   assign ovl_hit    = (state == ST_RUN) && (ovl_limit != 8'd0)
                     && (run_cnt == ovl_limit);
   // disable outranks overload, which outranks the sample tick
   assign tick_ev    = enable && tick && !ovl_hit;
   assign fifo_pop   = tick_ev && !fifo_empty;
   assign fifo_push  = s_valid && s_ready;
   assign s_ready    = !fifo_full && (state != ST_IDLE);

   always_comb begin
      if (pwm == 2'b00 || pwm != pwm_prev)
         run_nxt = 8'd0;
      else if (run_cnt == 8'hFF)
         run_nxt = 8'hFF;
      else
         run_nxt = run_cnt + 8'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (enable)     state_nxt = ST_FLUSH;
         ST_FLUSH:   if (flush_done) state_nxt = ST_RUN;
         ST_RUN:     if (ovl_hit)    state_nxt = ST_RECOVER;
         ST_RECOVER: if (flush_done) state_nxt = ST_RUN;
         default:                    state_nxt = ST_IDLE;
      endcase
      if (!enable) state_nxt = ST_IDLE;
   end

   sample_fifo #(
      .W     (T_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (!enable),
      .push  (fifo_push),
      .wdata (s_data),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         flush_cnt    <= 8'd0;
         tick_cnt     <= 8'd0;
         run_cnt      <= 8'd0;
         pwm_prev     <= 2'b00;
         overload_cnt <= 8'd0;
         lfsr         <= DSM_LFSR_SEED;
         dsm_reset    <= 1'b1;
         dsm_vin      <= '0;
         dsm_dith     <= '0;
         underrun     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pwm_prev <= pwm;

         if ((state == ST_FLUSH || state == ST_RECOVER) && state_nxt == state)
            flush_cnt <= flush_cnt + 8'd1;
         else
            flush_cnt <= 8'd0;

         if (state != ST_RUN || state_nxt != ST_RUN || tick)
            tick_cnt <= 8'd0;
         else
            tick_cnt <= tick_cnt + 8'd1;

         run_cnt <= (!enable || ovl_hit) ? 8'd0 : run_nxt;

         if (enable && ovl_hit && overload_cnt != 8'hFF)
            overload_cnt <= overload_cnt + 8'd1;

         if (dith_en)
            lfsr <= {^(lfsr & DSM_LFSR_TAPS), lfsr[15:1]};

         dsm_reset <= (state_nxt != ST_RUN);

         if (state_nxt == ST_IDLE || state_nxt == ST_FLUSH)
            dsm_vin <= '0;
         else if (fifo_pop)
            dsm_vin <= fifo_head;
         else if (tick_ev)
            dsm_vin <= '0;

         underrun <= tick_ev && fifo_empty;

         if (dith_en && state_nxt == ST_RUN)
            dsm_dith <= lfsr[T_BITS-6:0];
         else
            dsm_dith <= '0;
      end
   end

endmodule

// File: tb/tb_dsm_seq_ctrl.sv
// Scoreboard bench for dsm_seq_ctrl: a behavioural model predicts every
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_dsm_seq_ctrl;

   localparam int TB    = 15;
   localparam int DEPTH = 4;
   localparam int FLUSH = 4;
   localparam int S_IDLE = 0, S_FLUSH = 1, S_RUN = 2, S_RECOVER = 3;

   typedef struct {
      logic [1:0]    st;
      logic          rst;
      logic [TB-1:0] vin;
      logic [TB-6:0] dith;
      logic          und;
      logic [7:0]    ovl;
      logic          rdy;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [7:0]    osr;
   logic          dith_en;
   logic [7:0]    ovl_limit;
   logic          s_valid;
   logic          s_ready;
   logic [TB-1:0] s_data;
   logic [1:0]    pwm;
   logic          dsm_reset;
   logic [TB-1:0] dsm_vin;
   logic [TB-6:0] dsm_dith;
   logic          underrun;
   logic [7:0]    overload_cnt;
   logic [1:0]    state;

   int n_assert = 0;
   int n_fail   = 0;

   exp_t          exp_q[$];
   logic [TB-1:0] m_q[$];
   int            m_st = S_IDLE, m_hold = 0, m_ph = 0, m_run = 0, m_ovl = 0;
   logic [1:0]    m_prev = 2'b00;
   logic [TB-1:0] m_vin = '0;
   logic [TB-6:0] m_dith = '0;
   logic [15:0]   m_lfsr = 16'hACE1;

   always #5 clock = ~clock;

   dsm_seq_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .osr          (osr),
      .dith_en      (dith_en),
      .ovl_limit    (ovl_limit),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .pwm          (pwm),
      .dsm_reset    (dsm_reset),
      .dsm_vin      (dsm_vin),
      .dsm_dith     (dsm_dith),
      .underrun     (underrun),
      .overload_cnt (overload_cnt),
      .state        (state)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic model_step();
      int          osr_e;
      int          st_n;
      int          nrun;
      bit          acc;
      bit          hit;
      bit          und;
      logic [15:0] fb;
      und = 1'b0;
      if (reset) begin
         m_st = S_IDLE; m_hold = 0; m_ph = 0; m_run = 0; m_ovl = 0;
         m_q.delete();
         m_prev = 2'b00; m_vin = '0; m_dith = '0; m_lfsr = 16'hACE1;
      end else begin
         osr_e = (osr == 0) ? 1 : int'(osr);
         acc   = s_valid && (m_q.size() < DEPTH) && (m_st != S_IDLE);
         if (pwm == 2'b00 || pwm != m_prev) nrun = 0;
         else nrun = (m_run < 255) ? m_run + 1 : 255;
         hit  = (m_st == S_RUN) && (ovl_limit != 0) && (m_run == int'(ovl_limit));
         st_n = m_st;
         if (!enable) begin
            st_n = S_IDLE; m_q.delete(); m_vin = '0;
            m_run = 0; m_ph = 0; m_hold = 0;
         end else begin
            m_run = nrun;
            case (m_st)
               S_IDLE: begin st_n = S_FLUSH; m_hold = FLUSH; end
               S_FLUSH, S_RECOVER: begin
                  m_hold--;
                  if (m_hold == 0) begin st_n = S_RUN; m_ph = 0; end
               end
               default: begin
                  if (hit) begin
                     st_n = S_RECOVER; m_hold = FLUSH; m_run = 0; m_ph = 0;
                     if (m_ovl < 255) m_ovl++;
                  end else begin
                     m_ph++;
                     if (m_ph >= osr_e) begin
                        m_ph = 0;
                        if (m_q.size() > 0) m_vin = m_q.pop_front();
                        else begin m_vin = '0; und = 1'b1; end
                     end
                  end
               end
            endcase
            if (acc) m_q.push_back(s_data);
         end
         m_prev = pwm;
         m_dith = (dith_en && st_n == S_RUN) ? m_lfsr[TB-6:0] : '0;
         if (dith_en) begin
            fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
         end
         m_st = st_n;
      end
      exp_q.push_back('{st: 2'(m_st), rst: (m_st != S_RUN), vin: m_vin,
                        dith: m_dith, und: und, ovl: 8'(m_ovl),
                        rdy: (m_q.size() < DEPTH) && (m_st != S_IDLE)});
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("dsm_reset", 32'(dsm_reset), 32'(e.rst));
            chk("dsm_vin", 32'(dsm_vin), 32'(e.vin));
            chk("dsm_dith", 32'(dsm_dith), 32'(e.dith));
            chk("underrun", 32'(underrun), 32'(e.und));
            chk("overload_cnt", 32'(overload_cnt), 32'(e.ovl));
            chk("s_ready", 32'(s_ready), 32'(e.rdy));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; osr = 8'd3; dith_en = 1'b0;
      ovl_limit = 8'd0; s_valid = 1'b0; s_data = '0; pwm = 2'b00;
      cycles(2);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_dsm_reset", 32'(dsm_reset), 32'd1);
      reset = 1'b0;
      enable = 1'b1;
      cycles(4);
      chk("flush_state", 32'(state), 32'd1);
      cycles(1);
      chk("run_entry_state", 32'(state), 32'd2);
      chk("run_dsm_reset", 32'(dsm_reset), 32'd0);
      s_valid = 1'b1; s_data = 15'h1000;
      cycles(1);
      s_data = 15'h2000;
      cycles(1);
      s_valid = 1'b0;
      cycles(1);
      chk("first_tick_vin", 32'(dsm_vin), 32'h1000);
      cycles(3);
      chk("second_tick_vin", 32'(dsm_vin), 32'h2000);
      osr = 8'd2;
      cycles(12);
      ovl_limit = 8'd5; pwm = 2'b01;
      cycles(7);
      chk("recover_state", 32'(state), 32'd3);
      chk("recover_ovl_cnt", 32'(overload_cnt), 32'd1);
      pwm = 2'b00; ovl_limit = 8'd0;
      cycles(4);
      chk("recover_exit_state", 32'(state), 32'd2);
      dith_en = 1'b1;
      cycles(1);
      chk("first_dither", 32'(dsm_dith), 32'h0E1);
      cycles(20);
      dith_en = 1'b0;
      cycles(5);
      osr = 8'd200; s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = 15'(16'h0111 * (i + 1));
         cycles(1);
      end
      chk("full_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b0; enable = 1'b0;
      cycles(1);
      chk("disable_state", 32'(state), 32'd0);
      chk("disable_ovl_kept", 32'(overload_cnt), 32'd1);
      enable = 1'b1; osr = 8'd1;
      cycles(12);
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 399) == 0);
         enable = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 99) == 0) osr = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 149) == 0) ovl_limit = 8'($urandom_range(0, 8));
         if ($urandom_range(0, 29) == 0) dith_en = ~dith_en;
         if ($urandom_range(0, 5) == 0) pwm = 2'($urandom_range(0, 2));
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 15'($urandom);
         cycles(1);
      end
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
